// File: rtl/vram_pkg.sv
// Shared types and constants for the sprite VRAM write-side engine.
// pack_rgba builds the 13-bit {R,G,B,A} pixel word.
package vram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FILL,
        DONE
    } fill_state_t;

    localparam int PIXEL_WIDTH = 13;
    localparam int VRAM_HSIZE  = 160;
    localparam int VRAM_VSIZE  = 120;

    function automatic logic [PIXEL_WIDTH-1:0] pack_rgba(
        input logic [3:0] r,
        input logic [3:0] g,
        input logic [3:0] b,
        input logic       a
    );
        return {r, g, b, a};
    endfunction

endpackage

// File: rtl/vram_fill_clip.sv
// Clips a rectangle command against the VRAM bounds.
// Sums use one extra bit so x+w / y+h never wrap.
module vram_fill_clip
    import vram_pkg::*;
#(
    parameter int CWIDTH = 8,
    parameter int HSIZE  = VRAM_HSIZE,
    parameter int VSIZE  = VRAM_VSIZE
) (
    input  logic [CWIDTH-1:0] x,
    input  logic [CWIDTH-1:0] y,
    input  logic [CWIDTH-1:0] w,
    input  logic [CWIDTH-1:0] h,
    output logic [CWIDTH:0]   x_end,
    output logic [CWIDTH:0]   y_end,
    output logic              empty
);

    localparam logic [CWIDTH:0] HLIM = (CWIDTH+1)'(HSIZE);
    localparam logic [CWIDTH:0] VLIM = (CWIDTH+1)'(VSIZE);

    logic [CWIDTH:0] x_sum;
    logic [CWIDTH:0] y_sum;

    always_comb begin
        x_sum = {1'b0, x} + {1'b0, w};
        y_sum = {1'b0, y} + {1'b0, h};
        x_end = (x_sum > HLIM) ? HLIM : x_sum;
        y_end = (y_sum > VLIM) ? VLIM : y_sum;
        empty = ({1'b0, x} >= HLIM) || ({1'b0, y} >= VLIM)
             || (w == '0) || (h == '0);
    end

endmodule

// File: rtl/vram_rect_filler.sv
// Rectangle-fill engine driving the VRAM write port, one word per
// allowed cycle in raster order, row base advanced by addition.
module vram_rect_filler
    import vram_pkg::*;
#(
    parameter int DATA_WIDTH = PIXEL_WIDTH,
    parameter int HSIZE      = VRAM_HSIZE,
    parameter int VSIZE      = VRAM_VSIZE,
    parameter int SIZE       = HSIZE * VSIZE,
    parameter int ADDR_WIDTH = $clog2(SIZE),
    parameter int CWIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CWIDTH-1:0]     cmd_x,
    input  logic [CWIDTH-1:0]     cmd_y,
    input  logic [CWIDTH-1:0]     cmd_w,
    input  logic [CWIDTH-1:0]     cmd_h,
    input  logic [DATA_WIDTH-1:0] cmd_color,
    input  logic                  wr_allow,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done
);

    fill_state_t state, state_next;

    logic [CWIDTH-1:0]     cx, cy, cw, ch;
    logic [CWIDTH-1:0]     cur_x, cur_y;
    logic [DATA_WIDTH-1:0] color;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [CWIDTH:0]       x_end, y_end;
    logic                  empty;
    logic                  row_last, px_last;
    // Set when the final pixel is written, so DONE follows one cycle later.
    logic                  last_done;

    vram_fill_clip #(
        .CWIDTH (CWIDTH),
        .HSIZE  (HSIZE),
        .VSIZE  (VSIZE)
    ) u_clip (
        .x     (cx),
        .y     (cy),
        .w     (cw),
        .h     (ch),
        .x_end (x_end),
        .y_end (y_end),
        .empty (empty)
    );

    assign row_last = ({1'b0, cur_x} + (CWIDTH+1)'(1)) == x_end;
    assign px_last  = row_last
                   && (({1'b0, cur_y} + (CWIDTH+1)'(1)) == y_end);

    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (cmd_valid) state_next = SETUP;
            SETUP: state_next = empty ? DONE : FILL;
            FILL:  if (last_done) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            last_done <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            cw        <= '0;
            ch        <= '0;
            color     <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            row_base  <= '0;
        end else begin
            we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cx    <= cmd_x;
                        cy    <= cmd_y;
                        cw    <= cmd_w;
                        ch    <= cmd_h;
                        color <= cmd_color;
                    end
                end
                SETUP: begin
                    cur_x     <= cx;
                    cur_y     <= cy;
                    row_base  <= ADDR_WIDTH'(cy) * ADDR_WIDTH'(HSIZE);
                    last_done <= 1'b0;
                end
                FILL: begin
                    if (wr_allow && !last_done) begin
                        we    <= 1'b1;
                        waddr <= row_base + ADDR_WIDTH'(cur_x);
                        wdata <= color;
                        if (px_last) begin
                            last_done <= 1'b1;
                        end else if (row_last) begin
                            cur_x    <= cx;
                            cur_y    <= cur_y + 1'b1;
                            row_base <= row_base + ADDR_WIDTH'(HSIZE);
                        end else begin
                            cur_x <= cur_x + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_rect_filler.sv
// Self-checking bench: directed vector table, hand-written corner
// sequences and random commands against a raster reference model.
module tb_vram_rect_filler;
    import vram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x, cmd_y, cmd_w, cmd_h;
    logic [12:0] cmd_color;
    logic        wr_allow;
    logic        we;
    logic [14:0] waddr;
    logic [12:0] wdata;
    logic        busy;
    logic        done;

    int nchk  = 0;
    int npass = 0;

    vram_rect_filler dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .wr_allow  (wr_allow),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    typedef struct {
        logic [7:0]  x, y, w, h;
        logic [12:0] col;
        logic [15:0] pat;
        int          n, first, last, dcyc;
        string       name;
    } vec_t;

    // Drives one command, applies wr_allow (pattern or random), checks the
    // observed writes against a raster model and returns what was seen.
    task automatic run_cmd(input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] w, input logic [7:0] h,
                           input logic [12:0] col, input bit rnd,
                           input logic [15:0] pat, input string tag,
                           output int n, output int first_a,
                           output int last_a, output int dcyc);
        int exp_q[$];
        int got_q[$];
        bit al[$];
        int xe, ye, ones, edone;
        int bad_ord, bad_dat, bad_allow, bad_hold;
        int prev_a;
        logic [12:0] prev_d;
        bit fin, a;
        xe = (int'(x) + int'(w) > 160) ? 160 : int'(x) + int'(w);
        ye = (int'(y) + int'(h) > 120) ? 120 : int'(y) + int'(h);
        for (int yy = int'(y); yy < ye; yy++)
            for (int xx = int'(x); xx < xe; xx++)
                exp_q.push_back(yy * 160 + xx);
        bad_ord = 0; bad_dat = 0; bad_allow = 0; bad_hold = 0;
        fin = 0; dcyc = -1;
        cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = col;
        cmd_valid = 1'b1;
        wr_allow = 1'b1;
        prev_a = int'(waddr);
        prev_d = wdata;
        for (int c = 1; c <= 8000 && !fin; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                cmd_valid = 1'b0;
                chk({tag, " accepted"}, busy, 1);
            end
            if (we) begin
                got_q.push_back(int'(waddr));
                if (wdata !== col) bad_dat++;
                if (c < 3 || !al[c-3]) bad_allow++;
            end else if (int'(waddr) != prev_a || wdata !== prev_d) begin
                bad_hold++;
            end
            prev_a = int'(waddr);
            prev_d = wdata;
            if (done) begin
                dcyc = c;
                fin  = 1;
            end else if (c >= 2) begin
                if (rnd) a = ($urandom_range(0, 3) != 0);
                else     a = (c - 2 < 16) ? pat[c-2] : 1'b1;
                al.push_back(a);
                wr_allow = a;
            end
        end
        if (!fin) chk({tag, " timeout waiting done"}, 0, 1);
        edone = -2;
        if (exp_q.size() == 0) edone = 2;
        else begin
            ones = 0;
            foreach (al[k]) if (al[k]) begin
                ones++;
                if (ones == exp_q.size() && edone < 0) edone = k + 4;
            end
        end
        foreach (exp_q[i])
            if (i >= got_q.size() || got_q[i] != exp_q[i]) bad_ord++;
        chk({tag, " write count"}, got_q.size(), exp_q.size());
        chk({tag, " write order"}, bad_ord, 0);
        chk({tag, " write data"}, bad_dat, 0);
        chk({tag, " writes only when allowed"}, bad_allow, 0);
        chk({tag, " addr/data hold"}, bad_hold, 0);
        chk({tag, " done cycle"}, dcyc, edone);
        wr_allow = 1'b1;
        @(posedge clk); #1;
        chk({tag, " ready after done"}, {cmd_ready, busy}, 2'b10);
        n = got_q.size();
        first_a = (n > 0) ? got_q[0] : -1;
        last_a  = (n > 0) ? got_q[n-1] : -1;
    endtask

    vec_t vt[11];

    initial begin
        int n, fa, la, dc, wc, dn, bad;
        int q[$];
        bit switched;
        rst = 1'b1; cmd_valid = 1'b0; wr_allow = 1'b1;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;

        vt[0]  = '{2, 3, 3, 2, 13'h1FFF, 16'hFFFF, 6, 482, 644, 9, "basic"};
        vt[1]  = '{158, 119, 5, 4, 13'h0A5A, 16'hFFFF, 2, 19198, 19199, 5,
                   "clip br"};
        vt[2]  = '{5, 5, 0, 3, 13'h1234, 16'hFFFF, 0, 0, 0, 2, "w zero"};
        vt[3]  = '{160, 0, 4, 4, 13'h0F0F, 16'hFFFF, 0, 0, 0, 2, "x off"};
        vt[4]  = '{0, 0, 4, 1, 13'h1111, 16'hFF69, 4, 0, 3, 10, "stall"};
        vt[5]  = '{0, 0, 5, 0, 13'h0001, 16'hFFFF, 0, 0, 0, 2, "h zero"};
        vt[6]  = '{0, 120, 3, 3, 13'h0002, 16'hFFFF, 0, 0, 0, 2, "y off"};
        vt[7]  = '{0, 0, 255, 1, 13'h0777, 16'hFFFF, 160, 0, 159, 163,
                   "full row"};
        vt[8]  = '{100, 50, 200, 255, 13'h1ABC, 16'hFFFF, 4200, 8100,
                   19199, 4203, "big clip"};
        vt[9]  = '{0, 119, 1, 1, 13'h0055, 16'hFFFF, 1, 19040, 19040, 4,
                   "single bl"};
        vt[10] = '{159, 0, 1, 1, 13'h0066, 16'hFFFF, 1, 159, 159, 4,
                   "single tr"};

        repeat (2) @(posedge clk);
        #1;
        chk("reset we", we, 0);
        chk("reset waddr", waddr, 0);
        chk("reset wdata", wdata, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready after reset", cmd_ready, 1);

        foreach (vt[i]) begin
            run_cmd(vt[i].x, vt[i].y, vt[i].w, vt[i].h, vt[i].col, 1'b0,
                    vt[i].pat, vt[i].name, n, fa, la, dc);
            chk({vt[i].name, " tbl count"}, n, vt[i].n);
            chk({vt[i].name, " tbl done"}, dc, vt[i].dcyc);
            if (vt[i].n > 0) begin
                chk({vt[i].name, " tbl first"}, fa, vt[i].first);
                chk({vt[i].name, " tbl last"}, la, vt[i].last);
            end
        end

        // Reset in the middle of a 10x10 fill.
        cmd_x = 0; cmd_y = 0; cmd_w = 10; cmd_h = 10; cmd_color = 13'h0333;
        cmd_valid = 1'b1; wr_allow = 1'b1; wc = 0;
        for (int c = 1; c <= 40 && wc < 5; c++) begin
            @(posedge clk); #1;
            if (c == 1) cmd_valid = 1'b0;
            if (we) wc++;
        end
        chk("midreset writes before rst", wc, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset we", we, 0);
        chk("midreset waddr", waddr, 0);
        chk("midreset wdata", wdata, 0);
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        chk("midreset ready", cmd_ready, 0);
        @(posedge clk); #1;
        chk("midreset we held", we, 0);
        rst = 1'b0;
        #1;
        chk("midreset ready release", cmd_ready, 1);
        run_cmd(2, 3, 3, 2, 13'h1FFF, 1'b0, 16'hFFFF, "post reset",
                n, fa, la, dc);
        chk("post reset count", n, 6);
        chk("post reset done", dc, 9);

        // Back-to-back with cmd_valid held high across two commands.
        cmd_x = 1; cmd_y = 1; cmd_w = 2; cmd_h = 1; cmd_color = 13'h0101;
        cmd_valid = 1'b1; wr_allow = 1'b1;
        dn = 0; bad = 0; switched = 0;
        for (int c = 1; c <= 100 && dn < 2; c++) begin
            @(posedge clk); #1;
            if (busy && cmd_ready) bad++;
            if (we) q.push_back(int'(waddr));
            if (!switched && busy) begin
                cmd_x = 10; cmd_y = 2; cmd_w = 1; cmd_h = 2;
                cmd_color = 13'h0202;
                switched = 1;
            end
            if (done) begin
                dn++;
                if (dn == 2) cmd_valid = 1'b0;
            end
        end
        chk("b2b done count", dn, 2);
        chk("b2b ready low while busy", bad, 0);
        chk("b2b write count", q.size(), 4);
        if (q.size() == 4) begin
            chk("b2b w0", q[0], 161);
            chk("b2b w1", q[1], 162);
            chk("b2b w2", q[2], 330);
            chk("b2b w3", q[3], 490);
        end
        @(posedge clk); #1;
        chk("b2b idle after", busy, 0);

        // Random commands with random write-window gaps.
        for (int r = 0; r < 25; r++) begin
            logic [7:0] rx, ry, rw, rh;
            logic [12:0] rc;
            rx = 8'($urandom_range(0, 170));
            ry = 8'($urandom_range(0, 125));
            rw = 8'($urandom_range(0, 40));
            rh = 8'($urandom_range(0, 20));
            rc = pack_rgba(4'($urandom_range(0, 15)),
                           4'($urandom_range(0, 15)),
                           4'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)));
            run_cmd(rx, ry, rw, rh, rc, 1'b1, 16'hFFFF,
                    $sformatf("rand%0d", r), n, fa, la, dc);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
